// File: rtl/match_sequencer_pkg.sv
// Shared constants for the pong match sequencer: state encoding, endgame flag
// positions and default timing/lives values.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int EG_OVER = 0;
  localparam int EG_P1   = 1;
  localparam int EG_P2   = 2;

  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 30;

  localparam int NUM_PLAYERS = 2;

endpackage

// File: rtl/match_sequencer_frame_timer.sv
// Loadable frame down-counter: steps once per accepted animate pulse and
// flags when it has run down to zero. Shared by the SERVE and POINT waits.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  output logic         o_zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_step && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/match_sequencer.sv
// Pong game-flow controller: IDLE/SERVE/PLAY/POINT/OVER sequencing, life
// counters and endgame flags. Optional pause input behind MATCH_SEQ_PAUSE_EN.
module match_sequencer
  import match_pkg::*;
#(
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int LIVES_W      = 9,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int TMR_W        = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef MATCH_SEQ_PAUSE_EN
  input  logic               i_pause,
`endif
  input  logic               i_animate,
  input  logic               i_start,
  input  logic               i_miss1,
  input  logic               i_miss2,
  output logic               o_ball_rst,
  output logic               o_serve,
  output logic               o_play_en,
  output logic [LIVES_W-1:0] o_lives1,
  output logic [LIVES_W-1:0] o_lives2,
  output logic [2:0]         o_endgame,
  output logic [2:0]         o_state
);

  localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES_INIT);
  localparam logic [TMR_W-1:0]   SERVE_LD = TMR_W'(SERVE_FRAMES);
  localparam logic [TMR_W-1:0]   POINT_LD = TMR_W'(POINT_FRAMES);

  state_t               state_q, state_d;
  logic                 start_q;
  logic [LIVES_W-1:0]   lives_q   [NUM_PLAYERS];
  logic [LIVES_W-1:0]   lives_d   [NUM_PLAYERS];
  logic [LIVES_W-1:0]   lives_dec [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] miss_v;
  logic                 ball_rst_q, ball_rst_d;
  logic                 serve_q, serve_d;
  logic                 play_en_q, play_en_d;
  logic [2:0]           endgame_q, endgame_d;

  logic                 start_rise;
  logic                 paused;
  logic                 frame_tick;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_load_val;
  logic                 tmr_step;
  logic                 tmr_zero;

  assign start_rise = i_start & ~start_q;
  assign miss_v     = {i_miss2, i_miss1};

  // Pause only has meaning while a rally is being set up or played.
`ifdef MATCH_SEQ_PAUSE_EN
  assign paused = i_pause & (state_q inside {ST_SERVE, ST_PLAY, ST_POINT});
`else
  assign paused = 1'b0;
`endif

  assign frame_tick = i_animate & ~paused;
  assign tmr_step   = frame_tick & (state_q inside {ST_SERVE, ST_POINT});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      assign lives_dec[gi] = (miss_v[gi] && (lives_q[gi] != '0)) ?
                             (lives_q[gi] - 1'b1) : lives_q[gi];
    end
  endgenerate

  frame_timer #(
    .W(TMR_W)
  ) u_frame_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_step     (tmr_step),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    lives_d[0]   = lives_q[0];
    lives_d[1]   = lives_q[1];
    tmr_load     = 1'b0;
    tmr_load_val = SERVE_LD;
    serve_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d    = ST_SERVE;
          lives_d[0] = LIVES_LD;
          lives_d[1] = LIVES_LD;
          tmr_load   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick && tmr_zero) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!paused && (miss_v != '0)) begin
          lives_d[0] = lives_dec[0];
          lives_d[1] = lives_dec[1];
          if ((lives_dec[0] == '0) || (lives_dec[1] == '0)) begin
            state_d = ST_OVER;
          end else begin
            state_d      = ST_POINT;
            tmr_load     = 1'b1;
            tmr_load_val = POINT_LD;
          end
        end
      end
      ST_POINT: begin
        // Back to SERVE re-arms the serve wait; the release pulse comes from SERVE.
        if (frame_tick && tmr_zero) begin
          state_d  = ST_SERVE;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // While paused the ball is released from reset so it holds its position.
    play_en_d  = (state_d == ST_PLAY) && !paused;
    ball_rst_d = (state_d != ST_PLAY) && !paused;

    endgame_d = 3'b000;
    if (state_d == ST_OVER) begin
      endgame_d[EG_OVER] = 1'b1;
      endgame_d[EG_P1]   = (lives_d[0] == '0);
      endgame_d[EG_P2]   = (lives_d[1] == '0);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      lives_q[0] <= LIVES_LD;
      lives_q[1] <= LIVES_LD;
      ball_rst_q <= 1'b1;
      serve_q    <= 1'b0;
      play_en_q  <= 1'b0;
      endgame_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      start_q    <= i_start;
      lives_q[0] <= lives_d[0];
      lives_q[1] <= lives_d[1];
      ball_rst_q <= ball_rst_d;
      serve_q    <= serve_d;
      play_en_q  <= play_en_d;
      endgame_q  <= endgame_d;
    end
  end

  assign o_ball_rst = ball_rst_q;
  assign o_serve    = serve_q;
  assign o_play_en  = play_en_q;
  assign o_lives1   = lives_q[0];
  assign o_lives2   = lives_q[1];
  assign o_endgame  = endgame_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer with short serve/point waits and
// randomised frame gaps and miss patterns; pause scenario under MATCH_SEQ_PAUSE_EN.
module tb_match_sequencer;

  localparam int LI = 3;
  localparam int LW = 9;
  localparam int SF = 2;
  localparam int PF = 1;

  localparam logic [2:0] E_IDLE  = 3'd0;
  localparam logic [2:0] E_SERVE = 3'd1;
  localparam logic [2:0] E_PLAY  = 3'd2;
  localparam logic [2:0] E_POINT = 3'd3;
  localparam logic [2:0] E_OVER  = 3'd4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_animate = 1'b0;
  logic          i_start = 1'b0;
  logic          i_miss1 = 1'b0;
  logic          i_miss2 = 1'b0;
`ifdef MATCH_SEQ_PAUSE_EN
  logic          i_pause = 1'b0;
`endif
  logic          o_ball_rst, o_serve, o_play_en;
  logic [LW-1:0] o_lives1, o_lives2;
  logic [2:0]    o_endgame, o_state;

  int n_tests = 0;
  int n_fail  = 0;
  int l1 = LI;
  int l2 = LI;

  always #5 i_clk = ~i_clk;

  match_sequencer #(
    .LIVES_INIT   (LI),
    .LIVES_W      (LW),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF),
    .TMR_W        (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
`ifdef MATCH_SEQ_PAUSE_EN
    .i_pause    (i_pause),
`endif
    .i_animate  (i_animate),
    .i_start    (i_start),
    .i_miss1    (i_miss1),
    .i_miss2    (i_miss2),
    .o_ball_rst (o_ball_rst),
    .o_serve    (o_serve),
    .o_play_en  (o_play_en),
    .o_lives1   (o_lives1),
    .o_lives2   (o_lives2),
    .o_endgame  (o_endgame),
    .o_state    (o_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick(input logic a, input logic m1, input logic m2);
    i_animate = a;
    i_miss1   = m1;
    i_miss2   = m2;
    @(posedge i_clk);
    #1;
    i_animate = 1'b0;
    i_miss1   = 1'b0;
    i_miss2   = 1'b0;
  endtask

  // Start edge from IDLE/OVER: lives reload, endgame clears, SERVE entered.
  task automatic do_start(input bit hold);
    i_start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    l1 = LI;
    l2 = LI;
    n_tests++;
    if (o_state !== E_SERVE || o_lives1 !== LW'(LI) || o_lives2 !== LW'(LI) ||
        o_endgame !== 3'b000 || o_ball_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL start: state=%0d lives=%0d/%0d eg=%b brst=%b, required state=1 lives=%0d/%0d eg=000 brst=1",
               o_state, o_lives1, o_lives2, o_endgame, o_ball_rst, LI, LI);
    end
    if (!hold) i_start = 1'b0;
  endtask

  // Serve wait: release pulse exactly on the (SF+1)th animate after entry.
  task automatic serve_phase(input bit noise);
    int k = 0;
    int budget = 0;
    while (k < SF + 1 && budget < 100) begin
      repeat ($urandom_range(0, 2)) begin
        if (noise) i_start = 1'($urandom_range(0, 1));
        tick(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
        budget++;
        n_tests++;
        if (o_serve !== 1'b0 || o_state !== E_SERVE || o_ball_rst !== 1'b1 || o_play_en !== 1'b0) begin
          n_fail++;
          $display("FAIL serve_wait: serve=%b state=%0d brst=%b pen=%b, required serve=0 state=1 brst=1 pen=0",
                   o_serve, o_state, o_ball_rst, o_play_en);
        end
      end
      if (noise) i_start = 1'($urandom_range(0, 1));
      tick(1'b1, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
      k++;
      budget++;
      n_tests++;
      if (o_serve !== (k == SF + 1)) begin
        n_fail++;
        $display("FAIL serve_pulse: animate %0d serve=%b, required %b", k, o_serve, (k == SF + 1));
      end
    end
    n_tests++;
    if (k != SF + 1 || o_state !== E_PLAY || o_play_en !== 1'b1 || o_ball_rst !== 1'b0 ||
        o_lives1 !== LW'(l1) || o_lives2 !== LW'(l2)) begin
      n_fail++;
      $display("FAIL serve_done: animates=%0d state=%0d pen=%b brst=%b lives=%0d/%0d, required animates=%0d state=2 pen=1 brst=0 lives=%0d/%0d",
               k, o_state, o_play_en, o_ball_rst, o_lives1, o_lives2, SF + 1, l1, l2);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (o_serve !== 1'b0 || o_play_en !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_once: serve=%b pen=%b, required serve=0 pen=1", o_serve, o_play_en);
    end
  endtask

  // Point wait: SERVE re-entered on the (PF+1)th animate, no release pulse.
  task automatic point_phase(input bit noise);
    int k = 0;
    int budget = 0;
    while (k < PF + 1 && budget < 100) begin
      repeat ($urandom_range(0, 2)) begin
        if (noise) i_start = 1'($urandom_range(0, 1));
        tick(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
        budget++;
        n_tests++;
        if (o_state !== E_POINT || o_ball_rst !== 1'b1 || o_play_en !== 1'b0 ||
            o_lives1 !== LW'(l1) || o_lives2 !== LW'(l2)) begin
          n_fail++;
          $display("FAIL point_wait: state=%0d brst=%b pen=%b lives=%0d/%0d, required state=3 brst=1 pen=0 lives=%0d/%0d",
                   o_state, o_ball_rst, o_play_en, o_lives1, o_lives2, l1, l2);
        end
      end
      if (noise) i_start = 1'($urandom_range(0, 1));
      tick(1'b1, noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
      k++;
      budget++;
      n_tests++;
      if (o_state !== ((k == PF + 1) ? E_SERVE : E_POINT) || o_serve !== 1'b0) begin
        n_fail++;
        $display("FAIL point_exit: animate %0d state=%0d serve=%b, required state=%0d serve=0",
                 k, o_state, o_serve, (k == PF + 1) ? 1 : 3);
      end
    end
  endtask

  task automatic play_idle();
    repeat ($urandom_range(0, 3)) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_tests++;
      if (o_state !== E_PLAY || o_play_en !== 1'b1) begin
        n_fail++;
        $display("FAIL play_hold: state=%0d pen=%b, required state=2 pen=1", o_state, o_play_en);
      end
    end
  endtask

  task automatic do_miss(input logic m1, input logic m2);
    logic [2:0] eg_exp;
    logic [2:0] st_exp;
    if (m1 && l1 > 0) l1--;
    if (m2 && l2 > 0) l2--;
    st_exp = (l1 == 0 || l2 == 0) ? E_OVER : E_POINT;
    eg_exp = (st_exp == E_OVER) ? {(l2 == 0), (l1 == 0), 1'b1} : 3'b000;
    tick(1'b0, m1, m2);
    n_tests++;
    if (o_lives1 !== LW'(l1) || o_lives2 !== LW'(l2) || o_state !== st_exp ||
        o_endgame !== eg_exp || o_ball_rst !== 1'b1 || o_play_en !== 1'b0) begin
      n_fail++;
      $display("FAIL miss %b%b: lives=%0d/%0d state=%0d eg=%b brst=%b pen=%b, required lives=%0d/%0d state=%0d eg=%b brst=1 pen=0",
               m1, m2, o_lives1, o_lives2, o_state, o_endgame, o_ball_rst, o_play_en, l1, l2, st_exp, eg_exp);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    l1 = LI;
    l2 = LI;
    n_tests++;
    if (o_state !== E_IDLE || o_ball_rst !== 1'b1 || o_serve !== 1'b0 || o_play_en !== 1'b0 ||
        o_lives1 !== LW'(LI) || o_lives2 !== LW'(LI) || o_endgame !== 3'b000) begin
      n_fail++;
      $display("FAIL reset: state=%0d brst=%b serve=%b pen=%b lives=%0d/%0d eg=%b, required 0 1 0 0 %0d/%0d 000",
               o_state, o_ball_rst, o_serve, o_play_en, o_lives1, o_lives2, o_endgame, LI, LI);
    end
    repeat (4) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_tests++;
      if (o_state !== E_IDLE || o_lives1 !== LW'(LI) || o_lives2 !== LW'(LI)) begin
        n_fail++;
        $display("FAIL idle_ignore: state=%0d lives=%0d/%0d, required state=0 lives=%0d/%0d",
                 o_state, o_lives1, o_lives2, LI, LI);
      end
    end
  endtask

  task automatic test_serve();
    do_start(1'b0);
    serve_phase(1'b0);
  endtask

  task automatic test_miss();
    play_idle();
    do_miss(1'b1, 1'b0);
    n_tests++;
    if (o_lives1 !== LW'(2)) begin
      n_fail++;
      $display("FAIL miss1_once: lives1=%0d, required 2", o_lives1);
    end
    point_phase(1'b0);
    serve_phase(1'b0);
  endtask

  task automatic test_over();
    repeat (3) begin
      play_idle();
      do_miss(1'b0, 1'b1);
      if (l2 > 0) begin
        point_phase(1'b0);
        serve_phase(1'b0);
      end
    end
    n_tests++;
    if (o_lives2 !== LW'(0) || o_endgame !== 3'b101 || o_ball_rst !== 1'b1 || o_state !== E_OVER) begin
      n_fail++;
      $display("FAIL p2_out: lives2=%0d eg=%b brst=%b state=%0d, required 0 101 1 4",
               o_lives2, o_endgame, o_ball_rst, o_state);
    end
    repeat (4) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      n_tests++;
      if (o_lives1 !== LW'(2) || o_lives2 !== LW'(0) || o_state !== E_OVER || o_endgame !== 3'b101) begin
        n_fail++;
        $display("FAIL over_ignore: lives=%0d/%0d state=%0d eg=%b, required 2/0 4 101",
                 o_lives1, o_lives2, o_state, o_endgame);
      end
    end
  endtask

  task automatic test_ignored();
    do_start(1'b1);
    serve_phase(1'b1);
    i_start = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    i_start = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (o_state !== E_PLAY || o_lives1 !== LW'(LI) || o_lives2 !== LW'(LI)) begin
      n_fail++;
      $display("FAIL play_start_ignore: state=%0d lives=%0d/%0d, required 2 %0d/%0d",
               o_state, o_lives1, o_lives2, LI, LI);
    end
    do_miss(1'b1, 1'b0);
    point_phase(1'b1);
    serve_phase(1'b1);
    i_start = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_draw();
    logic m1, m2;
    int rounds = 0;
    while ((l1 > 1 || l2 > 1) && rounds < 10) begin
      m1 = (l1 > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      m2 = (l2 > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!m1 && !m2) begin
        if (l1 > 1) m1 = 1'b1;
        else m2 = 1'b1;
      end
      play_idle();
      do_miss(m1, m2);
      point_phase(1'b0);
      serve_phase(1'b0);
      rounds++;
    end
    do_miss(1'b1, 1'b1);
    n_tests++;
    if (o_lives1 !== LW'(0) || o_lives2 !== LW'(0) || o_endgame !== 3'b111) begin
      n_fail++;
      $display("FAIL draw: lives=%0d/%0d eg=%b, required 0/0 111", o_lives1, o_lives2, o_endgame);
    end
  endtask

  task automatic test_async_reset();
    do_start(1'b0);
    serve_phase(1'b0);
    do_miss(1'b1, 1'b0);
    point_phase(1'b0);
    serve_phase(1'b0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (o_play_en !== 1'b0 || o_ball_rst !== 1'b1 || o_lives1 !== LW'(LI) || o_lives2 !== LW'(LI) ||
        o_state !== E_IDLE || o_serve !== 1'b0 || o_endgame !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: pen=%b brst=%b lives=%0d/%0d state=%0d, required 0 1 %0d/%0d 0",
               o_play_en, o_ball_rst, o_lives1, o_lives2, o_state, LI, LI);
    end
    tick(1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    l1 = LI;
    l2 = LI;
  endtask

`ifdef MATCH_SEQ_PAUSE_EN
  task automatic test_pause();
    do_start(1'b0);
    for (int k = 1; k <= SF + 6; k++) begin
      i_pause = (k >= 2 && k <= 6);
      tick(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (o_serve !== (k == SF + 6) || o_state !== ((k == SF + 6) ? E_PLAY : E_SERVE)) begin
        n_fail++;
        $display("FAIL pause_serve: animate %0d serve=%b state=%0d, required serve=%b",
                 k, o_serve, o_state, (k == SF + 6));
      end
      if (i_pause && (o_ball_rst !== 1'b0 || o_play_en !== 1'b0)) begin
        n_fail++;
        $display("FAIL pause_outputs: brst=%b pen=%b, required 0 0", o_ball_rst, o_play_en);
      end
    end
    i_pause = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_serve();
    test_miss();
    test_over();
    test_ignored();
    test_draw();
    test_async_reset();
`ifdef MATCH_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
Name: match_sequencer

Overview:
Game-flow controller that sequences the pong ball/rocket datapath through idle, serve, play, point and game-over phases. It owns both players' life counters, holds the ball engine in reset between points, releases it with a serve pulse after a frame-counted delay, and drives the endgame flags consumed by the VGA driver and the colour logic. It sits beside the ball and rocket instances in the game top level and is clocked by the 100 MHz system clock.

Parameters:
- LIVES_INIT, 3: lives loaded per player at match start.
- LIVES_W, 9: life counter width; matches the existing 9-bit lives buses.
- SERVE_FRAMES, 60: animate frames held in SERVE before release.
- POINT_FRAMES, 30: animate frames held in POINT after a miss.
- TMR_W, 8: frame timer width; must satisfy SERVE_FRAMES and POINT_FRAMES < 2^TMR_W.

Ports:
- i_clk, input, 1: 100 MHz system clock.
- i_rst, input, 1: asynchronous, active-high reset.
- i_animate, input, 1: one-cycle pulse per frame, at end of active video.
- i_start, input, 1: start request, level-sampled; edge-detected internally.
- i_miss1, input, 1: one-cycle pulse; ball passed player 1's edge.
- i_miss2, input, 1: one-cycle pulse; ball passed player 2's edge.
- o_ball_rst, output, 1: holds the ball engines at their initial position.
- o_serve, output, 1: one-cycle release pulse to the ball engines.
- o_play_en, output, 1: high only in PLAY; gates rocket motion.
- o_lives1, output, LIVES_W: player 1 remaining lives.
- o_lives2, output, LIVES_W: player 2 remaining lives.
- o_endgame, output, 3: [0] match over; [1] player 1 out; [2] player 2 out.
- o_state, output, 3: current state encoding, for debug.

Behaviour:
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- Reset values: state IDLE; lives1 = lives2 = LIVES_INIT; timer 0; o_ball_rst 1; o_serve 0; o_play_en 0; o_endgame 0.
- Start edge: start_rise = i_start & ~start_q. start_q resets to 0.
- IDLE:
  - o_ball_rst=1.
  - On start_rise: go to SERVE, reload both lives to LIVES_INIT, timer = SERVE_FRAMES.
- SERVE:
  - o_ball_rst=1.
  - Timer decrements only on i_animate.
  - On the i_animate cycle with timer==0: go to PLAY and assert o_serve for exactly that one cycle.
  - Latency: o_serve occurs on the (SERVE_FRAMES+1)th animate pulse after entry.
- PLAY:
  - o_ball_rst=0, o_play_en=1.
  - A miss decrements that player's life counter, saturating at 0.
  - After the decrement, if any counter is 0, go to OVER; otherwise go to POINT with timer = POINT_FRAMES.
  - Simultaneous i_miss1 and i_miss2 decrement both counters in the same cycle.
- POINT:
  - o_ball_rst=1.
  - Counts down on i_animate as in SERVE.
  - On the i_animate cycle with timer==0: go to SERVE with timer = SERVE_FRAMES. No o_serve is issued here.
- OVER:
  - o_ball_rst=1.
  - o_endgame[0]=1; o_endgame[1] = (lives1==0); o_endgame[2] = (lives2==0). Both side bits set on a draw.
  - On start_rise: go to SERVE with lives reloaded and o_endgame cleared.
- Ignored inputs:
  - Misses outside PLAY.
  - start_rise in SERVE, PLAY and POINT.
- Outputs are registered; all changes take effect on the clock edge after the causing event.
- Reset asserted mid-match returns every output to its reset value immediately (asynchronous).

Optional Feature:
- Macro: MATCH_SEQ_PAUSE_EN.
- When defined:
  - Adds input i_pause (1 bit).
  - In PLAY, SERVE and POINT, i_pause=1 freezes the state and the timer, forces o_play_en=0 and o_ball_rst=0 (ball holds position), and drops misses.
  - Deasserting i_pause resumes in the same state with the timer unchanged.
- When undefined: no port, no pause logic.

Decomposition:
- Package match_pkg holds:
  - State localparams (ST_IDLE to ST_OVER).
  - Endgame bit indices (EG_OVER=0, EG_P1=1, EG_P2=2).
  - Default LIVES_INIT, SERVE_FRAMES and POINT_FRAMES.
- Sub-module frame_timer: loadable down-counter advanced by i_animate, with a zero flag. It is reused for both the SERVE and POINT waits.

Test Plan:
1. Reset, then start pulse, with SERVE_FRAMES=2 -> o_serve pulses once on the 3rd i_animate; o_play_en=1 the next cycle; lives1 = lives2 = 3.
2. In PLAY, one i_miss1 -> lives1=2, state POINT. With POINT_FRAMES=1, SERVE is reached after 2 animates, then a fresh serve follows.
3. Three i_miss2 events across points -> lives2=0, o_endgame=3'b101, o_ball_rst=1; further misses leave the lives unchanged.
4. Both lives at 1, with i_miss1 and i_miss2 in the same cycle -> both lives 0, o_endgame=3'b111.
5. Misses and start held high during SERVE and POINT -> no life change and no restart; only one start edge is counted.
6. i_rst asserted mid-PLAY, between clock edges -> o_play_en=0, o_ball_rst=1 and lives=3 immediately. With MATCH_SEQ_PAUSE_EN defined, pausing for 5 frames in SERVE delays o_serve by exactly 5 animates.
